// File: rtl/noc_pkg.sv
// Shared definitions for the NoC host interface.
// Holds the request-control field layout, the response status encodings,
// the host-interface FSM state type and the default mesh dimension.
package noc_pkg;

   // Field layout of the 16-bit request/flit control word.
   localparam int CTRL_W     = 16;
   localparam int FIELD_W    = 4;
   localparam int OP_LSB     = 0;
   localparam int DEST_X_LSB = 4;
   localparam int DEST_Y_LSB = 8;
   localparam int TAG_LSB    = 12;

   // Mesh dimension used when the top-level parameter is left at its default.
   localparam int GRID_DIM_DEF = 3;

   typedef enum logic [1:0] {
      STAT_OK       = 2'b00,
      STAT_TIMEOUT  = 2'b01,
      STAT_BAD_DEST = 2'b10
   } status_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_INJECT,
      S_WAIT,
      S_RESP
   } state_e;

endpackage : noc_pkg

// File: rtl/noc_host_if.sv
// Host-side bridge between a calculator request/response port and tile (0,0)
// of a mesh NoC. One packet in flight at a time: a request is checked against
// the mesh size, injected as a single one-cycle flit, and the block then waits
// for the tile's result (or a timeout) and presents it as a held response.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_a, req_b, req_ctrl     operands and control {tag, dest_y, dest_x, opcode}
//   host_in_a/b/ctrl/valid     flit towards tile (0,0); valid is a one-cycle pulse
//   host_out_a/valid           result from tile (0,0)
//   rsp_valid/rsp_ready        response handshake
//   rsp_data/status/tag        result, status (OK/TIMEOUT/BAD_DEST), request tag
//   busy                       high whenever the FSM is not idle
//   stray_cnt                  saturating count of unsolicited results
module noc_host_if
   import noc_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int GRID_DIM       = GRID_DIM_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [63:0]        req_a,
   input  logic [63:0]        req_b,
   input  logic [CTRL_W-1:0]  req_ctrl,
   output logic [63:0]        host_in_a,
   output logic [63:0]        host_in_b,
   output logic [CTRL_W-1:0]  host_in_ctrl,
   output logic               host_in_valid,
   input  logic [63:0]        host_out_a,
   input  logic               host_out_valid,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [63:0]        rsp_data,
   output logic [1:0]         rsp_status,
   output logic [3:0]         rsp_tag,
   output logic               busy,
   output logic [7:0]         stray_cnt
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e              state, state_nxt;
   status_e             status_q;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_inc;
   logic [FIELD_W-1:0]  dest_x, dest_y;
   logic                accept, dest_ok, timeout_hit, stray;

   assign dest_x      = req_ctrl[DEST_X_LSB +: FIELD_W];
   assign dest_y      = req_ctrl[DEST_Y_LSB +: FIELD_W];
   assign dest_ok     = (int'(dest_x) < GRID_DIM) && (int'(dest_y) < GRID_DIM);
   assign accept      = (state == S_IDLE) && req_valid && req_ready;
   assign cnt_inc     = cnt + CNT_W'(1);
   // Timeout fires on the edge where the counter reaches its last value.
   assign timeout_hit = (cnt_inc == CNT_LAST);
   assign stray       = host_out_valid && ((state == S_IDLE) || (state == S_RESP));
   assign rsp_status  = status_q;

   // NOTE: combinational blocks assign every output a default first so no
   // path leaves a signal unassigned, which would infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept) state_nxt = dest_ok ? S_INJECT : S_RESP;
         S_INJECT: state_nxt = host_out_valid ? S_RESP : S_WAIT;
         S_WAIT:   if (host_out_valid || timeout_hit) state_nxt = S_RESP;
         S_RESP:   if (rsp_valid && rsp_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // All outputs are registered from the next-state decision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready     <= 1'b0;
         busy          <= 1'b0;
         host_in_valid <= 1'b0;
         host_in_a     <= '0;
         host_in_b     <= '0;
         host_in_ctrl  <= '0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         status_q      <= STAT_OK;
         rsp_tag       <= '0;
         stray_cnt     <= '0;
         cnt           <= '0;
      end else begin
         req_ready     <= (state_nxt == S_IDLE);
         busy          <= (state_nxt != S_IDLE);
         host_in_valid <= (state_nxt == S_INJECT);

         if (state == S_INJECT)    cnt <= '0;
         else if (state == S_WAIT) cnt <= cnt_inc;

         if (accept) begin
            rsp_tag <= req_ctrl[TAG_LSB +: FIELD_W];
            if (dest_ok) begin
               host_in_a    <= req_a;
               host_in_b    <= req_b;
               host_in_ctrl <= req_ctrl;
            end else begin
               rsp_valid <= 1'b1;
               rsp_data  <= '0;
               status_q  <= STAT_BAD_DEST;
            end
         end

         case (state)
            // INJECT also takes a result so a zero-latency network is not lost.
            S_INJECT, S_WAIT: begin
               if (host_out_valid) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= host_out_a;
                  status_q  <= STAT_OK;
               end else if (state == S_WAIT && timeout_hit) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= '0;
                  status_q  <= STAT_TIMEOUT;
               end
            end
            S_RESP: if (rsp_ready) rsp_valid <= 1'b0;
            default: ;
         endcase

         if (stray && (stray_cnt != 8'hFF)) stray_cnt <= stray_cnt + 8'd1;
      end
   end

endmodule : noc_host_if

// File: tb/tb_noc_host_if.sv
// Directed self-checking bench for noc_host_if (TIMEOUT_CYCLES=16, GRID_DIM=3).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_noc_host_if;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [63:0] req_a, req_b;
   logic [15:0] req_ctrl;
   logic [63:0] host_in_a, host_in_b;
   logic [15:0] host_in_ctrl;
   logic        host_in_valid;
   logic [63:0] host_out_a;
   logic        host_out_valid;
   logic        rsp_valid, rsp_ready;
   logic [63:0] rsp_data;
   logic [1:0]  rsp_status;
   logic [3:0]  rsp_tag;
   logic        busy;
   logic [7:0]  stray_cnt;

   int n_vec = 0;
   int n_err = 0;

   noc_host_if #(.TIMEOUT_CYCLES(16), .GRID_DIM(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
      .host_in_a(host_in_a), .host_in_b(host_in_b),
      .host_in_ctrl(host_in_ctrl), .host_in_valid(host_in_valid),
      .host_out_a(host_out_a), .host_out_valid(host_out_valid),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_status(rsp_status), .rsp_tag(rsp_tag),
      .busy(busy), .stray_cnt(stray_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before 1 ms");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [15:0] ctrl);
      req_a     = a;
      req_b     = b;
      req_ctrl  = ctrl;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic take_rsp(input string tag);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, "_release"}, {rsp_valid, req_ready, busy}, 3'b010);
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_a = '0; req_b = '0; req_ctrl = '0;
      host_out_a = '0; host_out_valid = 1'b0; rsp_ready = 1'b0;

      // Reset values
      #12;
      check("rst_ctl", {req_ready, busy, host_in_valid, rsp_valid}, 4'b0000);
      check("rst_rsp", {rsp_status, rsp_tag, rsp_data}, '0);
      check("rst_host", {host_in_ctrl, host_in_a}, '0);
      check("rst_stray", stray_cnt, 8'd0);
      rst_n = 1'b1;
      tick();
      check("rdy_after_rst", {req_ready, busy}, 2'b10);

      // Basic transaction, result three cycles after the flit
      send(64'd5, 64'd7, 16'h1221);
      check("t1_flit", {host_in_valid, busy, req_ready, host_in_ctrl}, {3'b110, 16'h1221});
      check("t1_ops", {host_in_a[31:0], host_in_b[31:0]}, {32'd5, 32'd7});
      tick();
      check("t1_flit_1cyc", {host_in_valid, host_in_ctrl}, {1'b0, 16'h1221});
      tick();
      tick();
      check("t1_wait", rsp_valid, 1'b0);
      host_out_a = 64'd12; host_out_valid = 1'b1;
      tick();
      host_out_valid = 1'b0; host_out_a = '0;
      check("t1_rsp", {rsp_valid, rsp_status, rsp_tag, rsp_data}, {1'b1, 2'b00, 4'h1, 64'd12});
      take_rsp("t1");

      // Timeout: response 16 cycles after the flit appears
      send(64'd1, 64'd2, 16'h3111);
      check("to_flit", host_in_valid, 1'b1);
      for (int k = 1; k <= 15; k++) begin
         tick();
         check("to_early", rsp_valid, 1'b0);
      end
      tick();
      check("to_rsp", {rsp_valid, rsp_status, rsp_tag, rsp_data}, {1'b1, 2'b01, 4'h3, 64'd0});
      take_rsp("to");

      // Result and timeout in the same cycle: result wins
      send(64'd3, 64'd4, 16'h4111);
      for (int k = 1; k <= 15; k++) tick();
      check("race_pre", rsp_valid, 1'b0);
      host_out_a = 64'h77; host_out_valid = 1'b1;
      tick();
      host_out_valid = 1'b0;
      check("race_rsp", {rsp_valid, rsp_status, rsp_tag, rsp_data}, {1'b1, 2'b00, 4'h4, 64'h77});
      take_rsp("race");

      // Out-of-range destinations
      send(64'hAA, 64'hBB, 16'h5031);
      check("bdx_rsp", {rsp_valid, host_in_valid, rsp_status, rsp_tag, rsp_data},
            {2'b10, 2'b10, 4'h5, 64'd0});
      check("bdx_nocap", host_in_ctrl, 16'h4111);
      take_rsp("bdx");
      send(64'hAA, 64'hBB, 16'h6300);
      check("bdy_rsp", {rsp_valid, host_in_valid, rsp_status, rsp_tag},
            {2'b10, 2'b10, 4'h6});
      take_rsp("bdy");

      // Zero-latency result during the flit cycle
      send(64'd1, 64'd2, 16'h7222);
      check("zl_flit", {host_in_valid, host_in_ctrl}, {1'b1, 16'h7222});
      host_out_a = 64'hDEAD; host_out_valid = 1'b1;
      tick();
      host_out_valid = 1'b0; host_out_a = '0;
      check("zl_rsp", {rsp_valid, host_in_valid, rsp_status, rsp_tag, rsp_data},
            {2'b10, 2'b00, 4'h7, 64'hDEAD});
      check("zl_nostray", stray_cnt, 8'd0);

      // Response held for 10 cycles with a competing request present
      send(64'd9, 64'd9, 16'h9000);
      req_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         check("hold", {rsp_valid, req_ready, host_in_valid, rsp_status, rsp_tag, rsp_data},
               {3'b100, 2'b00, 4'h7, 64'hDEAD});
         tick();
      end
      req_valid = 1'b0;
      take_rsp("hold");

      // Stray results while idle: saturate at 255, data untouched
      for (int k = 1; k <= 300; k++) begin
         host_out_a = 64'h1234; host_out_valid = 1'b1;
         tick();
         host_out_valid = 1'b0;
         tick();
         if (k == 100) check("stray_100", stray_cnt, 8'd100);
         if (k == 255) check("stray_255", stray_cnt, 8'd255);
      end
      check("stray_sat", stray_cnt, 8'd255);
      check("stray_nodata", {rsp_valid, rsp_data}, {1'b0, 64'hDEAD});

      // Reset asserted while waiting
      send(64'd1, 64'd1, 16'h8111);
      tick();
      tick();
      check("rw_inwait", {busy, rsp_valid}, 2'b10);
      #2;
      rst_n = 1'b0;
      #1;
      check("rw_async", {req_ready, busy, host_in_valid, rsp_valid, rsp_status, rsp_tag}, '0);
      check("rw_regs", {stray_cnt, host_in_ctrl, rsp_data}, '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rw_rdy", req_ready, 1'b1);
      host_out_a = 64'h55; host_out_valid = 1'b1;
      tick();
      host_out_valid = 1'b0;
      check("rw_late_stray", {stray_cnt, rsp_valid}, {8'd1, 1'b0});
      for (int k = 0; k < 20; k++) begin
         tick();
         check("rw_no_rsp", {rsp_valid, rsp_data}, {1'b0, 64'd0});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_noc_host_if

// File: doc/noc_host_if.md
NOC_HOST_IF -- requirements
Module: noc_host_if

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, is the maximum number of WAIT cycles before a timeout response.
REQ-002 Parameter GRID_DIM, default 3, is the mesh dimension used for destination checking.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  calculator request valid.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_a / req_b  input  64 each  operands.
REQ-008 req_ctrl  input  16  control; [3:0] opcode, [7:4] dest_x, [11:8] dest_y, [15:12] tag.
REQ-009 host_in_a / host_in_b  output  64 each  flit operands to tile (0,0).
REQ-010 host_in_ctrl  output  16  flit control to tile (0,0).
REQ-011 host_in_valid  output  1  flit valid, one-cycle atomic flit.
REQ-012 host_out_a  input  64  result from tile (0,0).
REQ-013 host_out_valid  input  1  result valid.
REQ-014 rsp_valid  output  1  response valid.
REQ-015 rsp_ready  input  1  calculator accepts response.
REQ-016 rsp_data  output  64  result.
REQ-017 rsp_status  output  2  00 OK, 01 TIMEOUT, 10 BAD_DEST.
REQ-018 rsp_tag  output  4  req_ctrl[15:12] of the request being answered.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 stray_cnt  output  8  count of unsolicited host_out_valid pulses.

Function
REQ-021 The FSM SHALL use four states: IDLE, INJECT, WAIT and RESP; all outputs SHALL be registered.
REQ-022 req_ready SHALL be 1 only in IDLE; a transfer occurs when req_valid && req_ready.
REQ-023 On transfer with dest_x<GRID_DIM and dest_y<GRID_DIM: capture a/b/ctrl, go to INJECT; host_in_valid SHALL be 1 in the next cycle only.
REQ-024 On transfer with an out-of-range destination: no injection; go to RESP with status BAD_DEST and rsp_data 0.
REQ-025 host_in_a/b/ctrl SHALL hold the captured values from INJECT until the next capture; host_in_valid=0 outside INJECT.
REQ-026 INJECT SHALL last exactly one cycle, then go to WAIT with timeout counter cleared; host_out_valid seen during INJECT (zero-latency network) SHALL be accepted as the result.
REQ-027 In WAIT, host_out_valid SHALL capture host_out_a into rsp_data (status OK), go to RESP; rsp_valid SHALL rise the cycle after host_out_valid.
REQ-028 In WAIT, the counter SHALL increment each cycle; on reaching TIMEOUT_CYCLES-1 without host_out_valid, go to RESP with status TIMEOUT and rsp_data 0.
REQ-029 If host_out_valid and the timeout occur in the same cycle, result (OK) SHALL win.
REQ-030 In RESP, rsp_valid=1 and rsp_data/status/tag SHALL be stable until rsp_ready; on rsp_valid && rsp_ready go to IDLE (next request accepted one cycle later).
REQ-031 host_out_valid in IDLE or RESP SHALL be ignored for data and SHALL increment stray_cnt, saturating at 255.
REQ-032 At most one packet SHALL be in flight; no request is accepted outside IDLE.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, req_ready=0 during reset then 1 after, host_in_*=0, host_in_valid=0, rsp_valid=0, rsp_data=0, rsp_status=00, rsp_tag=0, busy=0, stray_cnt=0, counter=0.
REQ-034 Reset mid-operation SHALL abandon the in-flight packet without any response; a late host_out_valid after reset SHALL count as stray.

Structure
REQ-035 Package noc_pkg SHALL hold the ctrl field offsets and widths, the status encodings, the FSM state enum and GRID_DIM default.
REQ-036 The design SHALL be a single module with no sub-modules; the timeout counter is width $clog2(TIMEOUT_CYCLES).

Verification
REQ-037 Request a=5, b=7, ctrl=0x1221; model returns 12 three cycles after flit -> host_in_valid for one cycle with ctrl 0x1221; rsp_data=12, status OK, tag 1.
REQ-038 ctrl dest_x=3 -> no host_in_valid; rsp status BAD_DEST, data 0, the cycle after accept.
REQ-039 TIMEOUT_CYCLES=16, no host_out_valid -> rsp status TIMEOUT exactly 16 cycles after INJECT; valid and timeout forced in the same cycle -> OK.
REQ-040 host_out_valid in the same cycle as host_in_valid with value 0xDEAD -> rsp_data 0xDEAD, OK.
REQ-041 rsp_ready held low 10 cycles -> rsp fields stable and req_ready 0 throughout; 300 stray pulses in IDLE -> stray_cnt=255.
REQ-042 rst_n asserted in WAIT -> outputs at reset values asynchronously; no rsp_valid afterwards.
